fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 30 +++
 rtl/fwd_sel.sv | 23 ++
 rtl/fwd_hazard_unit.sv | 109 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Stage tags are sized for the widest supported config; narrower ones zero-extend.
package fwd_pkg;

    localparam int AW_MAX   = 8;
    localparam int NSRC_MAX = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef logic [AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic                       valid;
        logic                       we;
        logic                       load;
        reg_addr_t                  rd;
        reg_addr_t [NSRC_MAX-1:0]   rs;
        logic      [NSRC_MAX-1:0]   rs_used;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // Register 0 is hardwired, so it never produces a forwardable value.
    function automatic logic tag_match(input stage_tag_t t, input reg_addr_t r);
        return t.valid && t.we && (t.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Single-source operand select: MEM result wins over WB, else register file.
module fwd_sel
    import fwd_pkg::*;
(
    input  logic       en,
    input  reg_addr_t  addr,
    input  stage_tag_t mem_tag,
    input  stage_tag_t wb_tag,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (tag_match(mem_tag, addr)) begin
                sel = FWD_MEM;
            end else if (tag_match(wb_tag, addr)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use / branch hazard detection for a 5-stage pipe.
// Tracks EX/MEM/WB destination tags and derives stall and mux selects.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int AW    = 3,
    parameter int NSRC  = 2,
    parameter int BR_ID = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NSRC*AW-1:0] id_rs,
    input  logic [NSRC-1:0]   id_rs_used,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_branch,
    input  logic              flush,
    output logic              stall,
    output logic [NSRC*2-1:0] ex_fwd,
    output logic [NSRC*2-1:0] id_fwd,
    output logic [15:0]       stall_count
);

    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    stage_tag_t id_tag;

    logic load_use;
    logic br_stall;

    always_comb begin
        id_tag         = TAG_BUBBLE;
        id_tag.valid   = id_valid;
        id_tag.we      = id_we;
        id_tag.load    = id_load;
        id_tag.rd      = reg_addr_t'(id_rd);
        for (int i = 0; i < NSRC; i++) begin
            id_tag.rs[i]      = reg_addr_t'(id_rs[i*AW +: AW]);
            id_tag.rs_used[i] = id_rs_used[i];
        end
    end

    always_comb begin
        load_use = 1'b0;
        br_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_valid && id_rs_used[i]) begin
                if (tag_match(ex_q, id_tag.rs[i]) && ex_q.load) begin
                    load_use = 1'b1;
                end
                // A branch compares in ID, so even an ALU result in EX is too late.
                if (BR_ID != 0 && id_branch) begin
                    if (tag_match(ex_q, id_tag.rs[i]) ||
                        (tag_match(mem_q, id_tag.rs[i]) && mem_q.load)) begin
                        br_stall = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = load_use | br_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= TAG_BUBBLE;
            mem_q       <= TAG_BUBBLE;
            wb_q        <= TAG_BUBBLE;
            stall_count <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (id_valid && !stall && !flush) begin
                ex_q <= id_tag;
            end else begin
                ex_q <= TAG_BUBBLE;
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        fwd_sel u_ex_sel (
            .en      (ex_q.valid & ex_q.rs_used[g]),
            .addr    (ex_q.rs[g]),
            .mem_tag (mem_q),
            .wb_tag  (wb_q),
            .sel     (ex_fwd[g*2 +: 2])
        );

        if (BR_ID != 0) begin : g_id
            fwd_sel u_id_sel (
                .en      (id_valid & id_branch & id_rs_used[g]),
                .addr    (id_tag.rs[g]),
                .mem_tag (mem_q),
                .wb_tag  (wb_q),
                .sel     (id_fwd[g*2 +: 2])
            );
        end else begin : g_no_id
            assign id_fwd[g*2 +: 2] = FWD_RF;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test of fwd_hazard_unit: forwarding selects, stalls, reset and flush.
// Inputs change 2 units after each rising edge; outputs are checked 1 unit later.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [2:0]  id_rd;
    logic        id_we;
    logic        id_load;
    logic        id_branch;
    logic        flush;
    logic        stall;
    logic [3:0]  ex_fwd;
    logic [3:0]  id_fwd;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(.AW(3), .NSRC(2), .BR_ID(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_load     (id_load),
        .id_branch   (id_branch),
        .flush       (flush),
        .stall       (stall),
        .ex_fwd      (ex_fwd),
        .id_fwd      (id_fwd),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction in decode and let the combinational outputs settle.
    task automatic drive(input logic v, input logic [2:0] r0, input logic [2:0] r1,
                         input logic [1:0] used, input logic [2:0] rd,
                         input logic we, input logic ld, input logic br);
        id_valid   = v;
        id_rs      = {r1, r0};
        id_rs_used = used;
        id_rd      = rd;
        id_we      = we;
        id_load    = ld;
        id_branch  = br;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            tick();
            nop();
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        nop();
        tick();
        tick();
        reset = 1'b0;
        nop();
        chk("reset_stall", 16'(stall), 16'h0);
        chk("reset_ex_fwd", 16'(ex_fwd), 16'h0);
        chk("reset_id_fwd", 16'(id_fwd), 16'h0);
        chk("reset_count", stall_count, 16'h0);

        // add x3,x1,x2 ; add x4,x3,x1
        tick(); drive(1, 3'd1, 3'd2, 2'b11, 3'd3, 1, 0, 0);
        tick(); drive(1, 3'd3, 3'd1, 2'b11, 3'd4, 1, 0, 0);
        chk("alu_alu_stall", 16'(stall), 16'h0);
        tick(); nop();
        chk("alu_alu_ex_fwd", 16'(ex_fwd), 16'h1);
        drain();

        // add x3 ; nop ; sub x5,x2,x3
        tick(); drive(1, 3'd1, 3'd2, 2'b11, 3'd3, 1, 0, 0);
        tick(); nop();
        tick(); drive(1, 3'd2, 3'd3, 2'b11, 3'd5, 1, 0, 0);
        tick(); nop();
        chk("wb_fwd_rs1", 16'(ex_fwd), 16'h8);
        drain();

        // add x3 ; add x3 ; or x6,x3,x3
        tick(); drive(1, 3'd1, 3'd2, 2'b11, 3'd3, 1, 0, 0);
        tick(); drive(1, 3'd1, 3'd1, 2'b11, 3'd3, 1, 0, 0);
        tick(); drive(1, 3'd3, 3'd3, 2'b11, 3'd6, 1, 0, 0);
        chk("or_no_stall", 16'(stall), 16'h0);
        tick(); nop();
        chk("mem_priority", 16'(ex_fwd), 16'h5);
        drain();

        // lw x2 ; add x7,x2,x1
        tick(); drive(1, 3'd1, 3'd0, 2'b01, 3'd2, 1, 1, 0);
        tick(); drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("load_use_stall", 16'(stall), 16'h1);
        tick(); drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("load_use_release", 16'(stall), 16'h0);
        chk("load_use_bubble", 16'(ex_fwd), 16'h0);
        tick(); nop();
        chk("load_use_ex_fwd", 16'(ex_fwd), 16'h2);
        chk("load_use_count", stall_count, 16'd1);
        drain();

        // lw x4 ; beq x4,x0
        tick(); drive(1, 3'd1, 3'd0, 2'b01, 3'd4, 1, 1, 0);
        tick(); drive(1, 3'd4, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("ld_br_stall1", 16'(stall), 16'h1);
        tick(); drive(1, 3'd4, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("ld_br_stall2", 16'(stall), 16'h1);
        tick(); drive(1, 3'd4, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("ld_br_release", 16'(stall), 16'h0);
        chk("ld_br_id_fwd", 16'(id_fwd), 16'h2);
        tick(); nop();
        chk("ld_br_count", stall_count, 16'd3);
        drain();

        // add x4 ; beq x4,x0
        tick(); drive(1, 3'd1, 3'd2, 2'b11, 3'd4, 1, 0, 0);
        tick(); drive(1, 3'd4, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("alu_br_stall", 16'(stall), 16'h1);
        tick(); drive(1, 3'd4, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("alu_br_release", 16'(stall), 16'h0);
        chk("alu_br_id_fwd", 16'(id_fwd), 16'h1);
        tick(); nop();
        chk("alu_br_count", stall_count, 16'd4);
        drain();

        // x0 writers followed by x0 readers
        tick(); drive(1, 3'd1, 3'd2, 2'b11, 3'd0, 1, 0, 0);
        tick(); drive(1, 3'd0, 3'd0, 2'b01, 3'd0, 1, 1, 0);
        tick(); drive(1, 3'd0, 3'd0, 2'b11, 3'd0, 0, 0, 1);
        chk("x0_br_stall", 16'(stall), 16'h0);
        chk("x0_id_fwd", 16'(id_fwd), 16'h0);
        tick(); drive(1, 3'd0, 3'd0, 2'b11, 3'd1, 1, 0, 0);
        chk("x0_alu_stall", 16'(stall), 16'h0);
        tick(); nop();
        chk("x0_ex_fwd", 16'(ex_fwd), 16'h0);
        drain();

        // reset in the middle of a load-use stall
        tick(); drive(1, 3'd1, 3'd0, 2'b01, 3'd2, 1, 1, 0);
        tick(); drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("pre_reset_stall", 16'(stall), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("post_reset_stall", 16'(stall), 16'h0);
        chk("post_reset_count", stall_count, 16'h0);
        drain();

        // flush during a stall
        tick(); drive(1, 3'd1, 3'd0, 2'b01, 3'd2, 1, 1, 0);
        tick(); flush = 1'b1; drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("flush_stall", 16'(stall), 16'h1);
        tick(); flush = 1'b0; drive(1, 3'd2, 3'd1, 2'b11, 3'd7, 1, 0, 0);
        chk("flush_release", 16'(stall), 16'h0);
        chk("flush_count", stall_count, 16'd1);
        drain();

        // flush alone kills the producer entering EX
        tick(); flush = 1'b1; drive(1, 3'd1, 3'd2, 2'b11, 3'd3, 1, 0, 0);
        tick(); flush = 1'b0; drive(1, 3'd3, 3'd1, 2'b11, 3'd4, 1, 0, 0);
        tick(); nop();
        chk("flush_kill_fwd", 16'(ex_fwd), 16'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
